// File: rtl/dec3x8_pulse.sv
// dec3x8_pulse: 3-to-8 decoder that turns each accepted code into a one-hot
// pulse held for PULSE_LEN cycles, followed by a one-cycle DONE gap.
// Dropping E while the pulse is being driven aborts it without a DONE.

module dec3x8_pulse #(
    parameter int PULSE_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       E,
    input  logic [2:0] X,
    input  logic       XV,
    output logic       XR,
    output logic [7:0] Y,
    output logic       YV,
    output logic       DONE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // The counter holds the number of further DRIVE cycles after the current one.
    localparam logic [7:0] LOAD = 8'(PULSE_LEN - 1);

    state_t     state;
    logic [7:0] count;

    // Ready only when idle and enabled.
    assign XR = (state == IDLE) && E;

    // Pulse sequencer: accept, hold for PULSE_LEN cycles, then one DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= 8'd0;
            Y     <= 8'h00;
            YV    <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (XV && XR) begin
                        Y     <= 8'b1 << X;
                        YV    <= 1'b1;
                        count <= LOAD;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (!E) begin
                        // Abort takes priority over normal completion.
                        Y     <= 8'h00;
                        YV    <= 1'b0;
                        DONE  <= 1'b0;
                        count <= 8'd0;
                        state <= IDLE;
                    end else if (count != 8'd0) begin
                        count <= count - 8'd1;
                    end else begin
                        Y     <= 8'h00;
                        YV    <= 1'b0;
                        DONE  <= 1'b1;
                        state <= GAP;
                    end
                end
                GAP: begin
                    // The gap completes regardless of E.
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Y     <= 8'h00;
                    YV    <= 1'b0;
                    DONE  <= 1'b0;
                    count <= 8'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dec3x8_pulse.md
DEC3X8_PULSE -- requirements
Module: dec3x8_pulse

Interface
REQ-001 The block SHALL have one parameter: PULSE_LEN, default 4, the number of clock cycles a decoded one-hot output is held (legal range 1..255).
REQ-002 The block SHALL run on one clock and a reset that is synchronous and active-high.
REQ-003 Port list, in this order, SHALL be:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- E  input  1  enable; 0 blocks acceptance and aborts an active pulse
- X  input  3  binary code to decode
- XV  input  1  code valid
- XR  output  1  ready to accept a code
- Y  output  8  registered one-hot decoded output
- YV  output  1  high while Y holds a nonzero pulse
- DONE  output  1  one-cycle pulse when a pulse completes normally

Function
REQ-004 The block SHALL implement a three-state FSM: IDLE, DRIVE, GAP.
REQ-005 XR SHALL be combinational and equal to (state==IDLE) && E.
REQ-006 A code SHALL be accepted on a rising edge where XV && XR. XV without XR has no effect, and nothing is queued.
REQ-007 On acceptance the block SHALL:
- register Y <= 8'b1 << X, so X=3'd0 gives Y[0] and X=3'd7 gives Y[7];
- set YV <= 1;
- load the 8-bit down-counter with PULSE_LEN-1;
- enter DRIVE.
Latency from the accept edge to valid Y SHALL be 1 cycle.
REQ-008 In DRIVE with E=1:
- if counter != 0, the counter SHALL decrement and Y/YV SHALL hold;
- if counter == 0, the block SHALL set Y <= 0, YV <= 0, DONE <= 1, and enter GAP.
REQ-009 Y and YV SHALL be high for exactly PULSE_LEN cycles per accepted code, including PULSE_LEN=1.
REQ-010 Changes to X or XV during DRIVE or GAP SHALL be ignored. The decoded value is latched only at acceptance.
REQ-011 GAP SHALL last exactly one cycle, with DONE=1 and XR=0, then return to IDLE. DONE SHALL be 0 in all other cycles.
REQ-012 Minimum spacing between consecutive accepts SHALL be PULSE_LEN+2 cycles.
REQ-013 If E=0 on an edge while in DRIVE (abort), the block SHALL:
- set Y <= 0, YV <= 0, DONE <= 0;
- clear the counter;
- enter IDLE.
REQ-014 If E=0 in GAP, GAP SHALL complete normally; DONE still pulses.
REQ-015 Y SHALL be one-hot or all-zero at all times. YV SHALL equal |Y.
REQ-016 If rst is high on the same edge as an accept, reset SHALL win and the code SHALL be discarded.

Reset
REQ-017 On a rising edge with rst=1, the block SHALL set:
- state = IDLE, counter = 0;
- Y = 8'h00, YV = 0, DONE = 0.
XR then follows E.
REQ-018 Reset asserted in DRIVE or GAP SHALL abort immediately, with no DONE pulse.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Basic decode: PULSE_LEN=4, E=1, X=3'd5 with XV for 1 cycle -> Y=8'h20 and YV=1 for cycles 1..4 after accept; DONE=1 in cycle 5; XR=1 again in cycle 6.
- Full sweep: X=0..7, back-to-back with XV held high -> Y sequence 01,02,04,...,80; each accept exactly 6 cycles apart; 8 DONE pulses.
- Minimum length: PULSE_LEN=1, X=3'd3 -> Y=8'h08 for exactly 1 cycle; DONE on the next cycle.
- Abort: PULSE_LEN=8, X=3'd6 accepted; E=0 on the 3rd DRIVE cycle -> Y=00 and YV=0 on the next cycle; DONE never asserts; XR=0 until E returns to 1.
- Disabled input: E=0, XV=1, X=3'd2 -> XR=0, Y stays 00, no accept; after E rises, accept occurs on the first edge where E=1.
- Reset mid-pulse: rst=1 during DRIVE with Y=8'h80 -> next cycle Y=00, YV=0, DONE=0, state IDLE.
- Reset coincident with accept -> no pulse issued.
- Continuous checks: a one-hot assertion on Y and the YV==|Y invariant on every cycle.
